// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the
// ID/EX operand stage. The master drives ID fields and forwarding taps;
// the slave (the operand stage) drives the EX-side operands and controls.
interface id_ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    // ID stage fields
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [RA_W-1:0] id_rd_addr;
    logic [3:0]      id_ALUSel;
    logic            id_asel;
    logic            id_bsel;
    logic            id_regwen;
    logic            id_memread;
    logic            id_memwrite;

    // Pipeline control
    logic            flush;
    logic            hold;

    // Forwarding taps from EX/MEM and MEM/WB
    logic            mem_regwen;
    logic [RA_W-1:0] mem_rd_addr;
    logic [XLEN-1:0] mem_alu_result;
    logic            wb_regwen;
    logic [RA_W-1:0] wb_rd_addr;
    logic [XLEN-1:0] wb_data;

    // EX-side results
    logic [XLEN-1:0] outmux1;
    logic [XLEN-1:0] outmux2;
    logic [3:0]      ALUSel;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_regwen;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_valid;
    logic            stall_id;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_ALUSel,
               id_asel, id_bsel, id_regwen, id_memread, id_memwrite,
               flush, hold,
               mem_regwen, mem_rd_addr, mem_alu_result,
               wb_regwen, wb_rd_addr, wb_data,
        input  outmux1, outmux2, ALUSel, ex_store_data, ex_pc, ex_rd_addr,
               ex_regwen, ex_memread, ex_memwrite, ex_valid, stall_id
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_ALUSel,
               id_asel, id_bsel, id_regwen, id_memread, id_memwrite,
               flush, hold,
               mem_regwen, mem_rd_addr, mem_alu_result,
               wb_regwen, wb_rd_addr, wb_data,
        output outmux1, outmux2, ALUSel, ex_store_data, ex_pc, ex_rd_addr,
               ex_regwen, ex_memread, ex_memwrite, ex_valid, stall_id
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX operand selection: captures decoded ID
// fields, forwards from EX/MEM and MEM/WB, detects load-use hazards and
// inserts bubbles on stall or flush. Freezes completely on hold.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic [3:0]      alusel;
        logic            asel;
        logic            bsel;
        logic            regwen;
        logic            memread;
        logic            memwrite;
        logic            valid;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use hazard: a load in EX whose destination the ID instruction reads.
    assign load_use = ex_q.memread && ex_q.valid && (ex_q.rd_addr != '0) && bus.id_valid
                    && ((ex_q.rd_addr == bus.id_rs1_addr) || (ex_q.rd_addr == bus.id_rs2_addr));

    assign bus.stall_id = load_use && !bus.flush;

    // Next-state selection: hold, bubble (flush or load-use) or capture of ID.
    always_comb begin
        // NOTE: defaulting to the current value first means every path assigns ex_d, so no latch.
        ex_d = ex_q;
        if (bus.hold) begin
            ex_d = ex_q;
        end else if (bus.flush || load_use) begin
            // Operands are kept; only the enables and forwarding keys are cleared.
            ex_d.valid    = 1'b0;
            ex_d.regwen   = 1'b0;
            ex_d.memread  = 1'b0;
            ex_d.memwrite = 1'b0;
            ex_d.rd_addr  = '0;
            ex_d.rs1_addr = '0;
            ex_d.rs2_addr = '0;
            ex_d.alusel   = 4'b0000;
        end else begin
            ex_d.valid    = bus.id_valid;
            ex_d.pc       = bus.id_pc;
            ex_d.imm      = bus.id_imm;
            ex_d.rs1_addr = bus.id_rs1_addr;
            ex_d.rs2_addr = bus.id_rs2_addr;
            ex_d.rd_addr  = bus.id_rd_addr;
            ex_d.alusel   = bus.id_ALUSel;
            ex_d.asel     = bus.id_asel;
            ex_d.bsel     = bus.id_bsel;
            ex_d.regwen   = bus.id_regwen;
            ex_d.memread  = bus.id_memread;
            ex_d.memwrite = bus.id_memwrite;
            // Same-cycle register file write is not yet visible on the read port.
            ex_d.rs1_data = (bus.wb_regwen && (bus.wb_rd_addr != '0)
                             && (bus.wb_rd_addr == bus.id_rs1_addr)) ? bus.wb_data : bus.id_rs1_data;
            ex_d.rs2_data = (bus.wb_regwen && (bus.wb_rd_addr != '0)
                             && (bus.wb_rd_addr == bus.id_rs2_addr)) ? bus.wb_data : bus.id_rs2_data;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    // Operand forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        fwd_rs2 = ex_q.rs2_data;
        if (bus.mem_regwen && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == ex_q.rs1_addr))
            fwd_rs1 = bus.mem_alu_result;
        else if (bus.wb_regwen && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == ex_q.rs1_addr))
            fwd_rs1 = bus.wb_data;
        if (bus.mem_regwen && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == ex_q.rs2_addr))
            fwd_rs2 = bus.mem_alu_result;
        else if (bus.wb_regwen && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == ex_q.rs2_addr))
            fwd_rs2 = bus.wb_data;
    end

    assign bus.outmux1       = ex_q.asel ? ex_q.pc : fwd_rs1;
    assign bus.outmux2       = ex_q.bsel ? ex_q.imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ALUSel        = ex_q.alusel;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_regwen     = ex_q.regwen;
    assign bus.ex_memread    = ex_q.memread;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_valid      = ex_q.valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: reset, a forwarding vector
// table, hand sequences for hazards/flush/hold/bypass, then random traffic
// against a model of "which instruction sits in EX".
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    id_ex_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently occupying EX.
    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        asel, bsel, regwen, memread, memwrite;
    } ex_m_t;

    ex_m_t m;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, pc, imm;
        logic        asel, bsel;
        logic        mr; logic [4:0] mrd; logic [31:0] mres;
        logic        wr; logic [4:0] wrd; logic [31:0] wdat;
        logic [31:0] e1, e2, es;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard(ex_m_t cur);
        return cur.valid && cur.memread && cur.rd != 5'd0 && bus.id_valid
               && (cur.rd == bus.id_rs1_addr || cur.rd == bus.id_rs2_addr);
    endfunction

    function automatic logic [31:0] model_fwd(logic [4:0] a, logic [31:0] d);
        if (a == 5'd0) return d;
        if (bus.mem_regwen && bus.mem_rd_addr == a) return bus.mem_alu_result;
        if (bus.wb_regwen && bus.wb_rd_addr == a) return bus.wb_data;
        return d;
    endfunction

    function automatic logic [31:0] reg_read(logic [4:0] a, logic [31:0] d);
        if (bus.wb_regwen && a != 5'd0 && bus.wb_rd_addr == a) return bus.wb_data;
        return d;
    endfunction

    function automatic ex_m_t model_next(ex_m_t cur);
        ex_m_t n = cur;
        if (rst) begin
            n = '{default: '0};
        end else if (bus.hold) begin
            n = cur;
        end else if (bus.flush || model_hazard(cur)) begin
            n.valid = 0; n.regwen = 0; n.memread = 0; n.memwrite = 0;
            n.rd = 0; n.rs1 = 0; n.rs2 = 0; n.op = 0;
        end else begin
            n.valid = bus.id_valid;   n.pc = bus.id_pc;       n.imm = bus.id_imm;
            n.rs1 = bus.id_rs1_addr;  n.rs2 = bus.id_rs2_addr; n.rd = bus.id_rd_addr;
            n.op = bus.id_ALUSel;     n.asel = bus.id_asel;    n.bsel = bus.id_bsel;
            n.regwen = bus.id_regwen; n.memread = bus.id_memread; n.memwrite = bus.id_memwrite;
            n.d1 = reg_read(bus.id_rs1_addr, bus.id_rs1_data);
            n.d2 = reg_read(bus.id_rs2_addr, bus.id_rs2_data);
        end
        return n;
    endfunction

    // Compare every output against the model under the current forwarding taps.
    task automatic check_model();
        logic [31:0] r1, r2;
        r1 = model_fwd(m.rs1, m.d1);
        r2 = model_fwd(m.rs2, m.d2);
        check("m_outmux1", bus.outmux1, m.asel ? m.pc : r1);
        check("m_outmux2", bus.outmux2, m.bsel ? m.imm : r2);
        check("m_store",   bus.ex_store_data, r2);
        check("m_alusel",  32'(bus.ALUSel), 32'(m.op));
        check("m_pc",      bus.ex_pc, m.pc);
        check("m_rd",      32'(bus.ex_rd_addr), 32'(m.rd));
        check("m_ctrl",    {28'd0, bus.ex_valid, bus.ex_regwen, bus.ex_memread, bus.ex_memwrite},
                           {28'd0, m.valid, m.regwen, m.memread, m.memwrite});
        check("m_stall",   32'(bus.stall_id), 32'(model_hazard(m) && !bus.flush));
    endtask

    // Advance one clock, keeping the model in step with the inputs at the edge.
    task automatic tick();
        ex_m_t nxt;
        nxt = model_next(m);
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic clear_fwd();
        bus.mem_regwen = 0; bus.mem_rd_addr = 0; bus.mem_alu_result = 0;
        bus.wb_regwen = 0;  bus.wb_rd_addr = 0;  bus.wb_data = 0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                          input logic [31:0] d1, d2, imm, input logic [3:0] op,
                          input logic asel, bsel, regwen, memread, memwrite);
        bus.id_valid = v;       bus.id_pc = pc;
        bus.id_rs1_addr = rs1;  bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
        bus.id_rs1_data = d1;   bus.id_rs2_data = d2;  bus.id_imm = imm;
        bus.id_ALUSel = op;     bus.id_asel = asel;    bus.id_bsel = bsel;
        bus.id_regwen = regwen; bus.id_memread = memread; bus.id_memwrite = memwrite;
    endtask

    task automatic randomize_inputs();
        set_id(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.hold  = ($urandom_range(0, 9) == 0);
        bus.mem_regwen = 1'($urandom_range(0, 1)); bus.mem_rd_addr = 5'($urandom_range(0, 7));
        bus.mem_alu_result = $urandom;
        bus.wb_regwen = 1'($urandom_range(0, 1));  bus.wb_rd_addr = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
    endtask

    initial begin
        m = '{default: '0};
        vecs[0] = '{5'd1, 5'd2, 32'h5,  32'h7,  32'h100,  32'h0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h5,    32'h7,  32'h7};
        vecs[1] = '{5'd3, 5'd9, 32'h33, 32'h99, 32'h104,  32'h0, 1'b0, 1'b0,
                    1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h11,   32'h99, 32'h99};
        vecs[2] = '{5'd3, 5'd9, 32'h33, 32'h99, 32'h108,  32'h0, 1'b0, 1'b0,
                    1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h22,   32'h99, 32'h99};
        vecs[3] = '{5'd0, 5'd9, 32'h44, 32'h99, 32'h10c,  32'h0, 1'b0, 1'b0,
                    1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 32'h44,   32'h99, 32'h99};
        vecs[4] = '{5'd3, 5'd9, 32'h33, 32'h99, 32'h1000, 32'h8, 1'b1, 1'b1,
                    1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,  32'h1000, 32'h8,  32'h99};
        vecs[5] = '{5'd2, 5'd9, 32'h2,  32'h99, 32'h110,  32'h0, 1'b0, 1'b0,
                    1'b1, 5'd9, 32'h66, 1'b1, 5'd9, 32'h55, 32'h2,    32'h66, 32'h66};
        vecs[6] = '{5'd8, 5'd9, 32'h88, 32'h99, 32'h114,  32'h0, 1'b0, 1'b0,
                    1'b1, 5'd8, 32'h77, 1'b1, 5'd9, 32'h55, 32'h77,   32'h55, 32'h55};

        // Reset with arbitrary inputs: everything clears.
        randomize_inputs();
        rst = 1'b1;
        tick();
        check("rst_outmux1", bus.outmux1, 32'h0);
        check("rst_outmux2", bus.outmux2, 32'h0);
        check("rst_alusel",  32'(bus.ALUSel), 32'h0);
        check("rst_ctrl",    {27'd0, bus.ex_valid, bus.ex_regwen, bus.ex_memread, bus.ex_memwrite,
                              bus.stall_id}, 32'h0);
        check("rst_pc_rd",   bus.ex_pc | 32'(bus.ex_rd_addr), 32'h0);
        tick();
        rst = 1'b0;
        bus.flush = 0; bus.hold = 0;
        clear_fwd();

        // Forwarding table: capture with no bypass, then apply the EX-cycle taps.
        for (int i = 0; i < 7; i++) begin
            clear_fwd();
            set_id(1, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 5'd1, vecs[i].d1, vecs[i].d2,
                   vecs[i].imm, 4'(i), vecs[i].asel, vecs[i].bsel, 1, 0, 0);
            tick();
            bus.id_valid = 0;
            bus.mem_regwen = vecs[i].mr; bus.mem_rd_addr = vecs[i].mrd; bus.mem_alu_result = vecs[i].mres;
            bus.wb_regwen = vecs[i].wr;  bus.wb_rd_addr = vecs[i].wrd;  bus.wb_data = vecs[i].wdat;
            #1;
            check($sformatf("tbl%0d_outmux1", i), bus.outmux1, vecs[i].e1);
            check($sformatf("tbl%0d_outmux2", i), bus.outmux2, vecs[i].e2);
            check($sformatf("tbl%0d_store", i), bus.ex_store_data, vecs[i].es);
            check($sformatf("tbl%0d_alusel", i), 32'(bus.ALUSel), i);
            check($sformatf("tbl%0d_valid", i), 32'(bus.ex_valid), 32'h1);
        end

        // Load-use: lw x4 in EX, dependent in ID -> stall, bubble, then WB forward.
        clear_fwd();
        set_id(1, 32'h200, 5'd1, 5'd2, 5'd4, 32'h10, 32'h20, 32'h0, 4'h0, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 32'h204, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 4'h0, 0, 0, 1, 0, 0);
        #1;
        check("lu_stall", 32'(bus.stall_id), 32'h1);
        tick();
        check("lu_bubble", {29'd0, bus.ex_valid, bus.ex_regwen, bus.ex_memread}, 32'h0);
        check("lu_unstall", 32'(bus.stall_id), 32'h0);
        bus.mem_regwen = 1; bus.mem_rd_addr = 5'd4; bus.mem_alu_result = 32'h3000;
        tick();
        clear_fwd();
        bus.wb_regwen = 1; bus.wb_rd_addr = 5'd4; bus.wb_data = 32'hDEAD;
        bus.id_valid = 0;
        #1;
        check("lu_fwd_wb", bus.outmux1, 32'hDEAD);
        check("lu_valid",  32'(bus.ex_valid), 32'h1);

        // Flush together with a load-use condition: flush wins, no stall.
        clear_fwd();
        set_id(1, 32'h208, 5'd1, 5'd2, 5'd4, 32'h10, 32'h20, 32'h0, 4'h0, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 32'h20c, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 4'h2, 0, 0, 1, 0, 0);
        bus.flush = 1;
        #1;
        check("fl_stall", 32'(bus.stall_id), 32'h0);
        tick();
        check("fl_bubble", {27'd0, bus.ex_rd_addr} | {31'd0, bus.ex_valid} | {30'd0, bus.ex_memread, 1'b0},
              32'h0);
        bus.flush = 0;

        // Hold with flush: registers keep their contents.
        set_id(1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 32'h0, 4'h3, 0, 0, 1, 0, 0);
        tick();
        set_id(1, 32'h400, 5'd3, 5'd4, 5'd8, 32'h55, 32'h66, 32'h0, 4'h5, 1, 1, 0, 1, 1);
        bus.flush = 1; bus.hold = 1;
        tick();
        check("hold_pc",      bus.ex_pc, 32'h300);
        check("hold_outmux1", bus.outmux1, 32'h11);
        check("hold_alusel",  32'(bus.ALUSel), 32'h3);
        check("hold_rd",      32'(bus.ex_rd_addr), 32'h7);
        check("hold_valid",   32'(bus.ex_valid), 32'h1);
        bus.flush = 0; bus.hold = 0;

        // Capture bypass for rs2 with an immediate B operand.
        set_id(1, 32'h500, 5'd1, 5'd6, 5'd9, 32'h1, 32'h0, 32'hFFFFFFF0, 4'h0, 0, 1, 0, 0, 1);
        bus.wb_regwen = 1; bus.wb_rd_addr = 5'd6; bus.wb_data = 32'hABCD;
        tick();
        clear_fwd();
        #1;
        check("byp_outmux2", bus.outmux2, 32'hFFFFFFF0);
        check("byp_store",   bus.ex_store_data, 32'hABCD);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 49) == 0);
            #1;
            check_model();
            tick();
        end
        rst = 0;
        clear_fwd();
        #1;
        check_model();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and EX operand-select stage for the RV32 five-stage pipeline; sits directly upstream of the ALU and drives its outmux1, outmux2 and ALUSel inputs. It captures decoded ID fields each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards. It inserts bubbles on stall or branch flush and freezes on external hold.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  ID instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register indices
id_ALUSel  in  4  ALU opcode, ALU encoding
id_asel  in  1  0=rs1, 1=pc
id_bsel  in  1  0=rs2, 1=imm
id_regwen, id_memread, id_memwrite  in  1  control
flush  in  1  branch/jump taken in EX; squash ID
hold  in  1  global freeze (memory wait)
mem_regwen  in  1  EX/MEM writes a register
mem_rd_addr  in  RA_W  EX/MEM destination
mem_alu_result  in  XLEN  EX/MEM result
wb_regwen  in  1  MEM/WB writes a register
wb_rd_addr  in  RA_W  MEM/WB destination
wb_data  in  XLEN  MEM/WB writeback value
outmux1, outmux2  out  XLEN  ALU operands A and B
ALUSel  out  4  ALU opcode
ex_store_data  out  XLEN  forwarded rs2, used for stores
ex_pc  out  XLEN  EX PC
ex_rd_addr  out  RA_W  EX destination
ex_regwen, ex_memread, ex_memwrite, ex_valid  out  1  EX control
stall_id  out  1  load-use stall request to IF/ID

Behaviour:
- Registered state: pc, rs1/rs2 data, imm, rs1/rs2/rd addr, ALUSel, asel, bsel, regwen, memread, memwrite, valid.
- rst: every register cleared to 0. Resulting outputs: outmux1=0, outmux2=0, ALUSel=0000, all control outputs 0, stall_id=0.
- Per-edge update priority: rst > hold > flush > load-use bubble > load.
  - hold=1: all registers keep their values. A flush coincident with hold is ignored; the source keeps flush asserted until hold drops.
  - flush=1: load a bubble.
  - load_use=1: load a bubble.
  - Otherwise: load the ID fields.
- Bubble: valid, regwen, memread, memwrite, rd, rs1, rs2 and ALUSel all 0.
- Capture bypass: on load, if wb_regwen, wb_rd_addr!=0 and wb_rd_addr equals id_rs1_addr (or id_rs2_addr), capture wb_data instead of the register file data. This covers same-cycle regfile write/read.
- load_use (combinational) = ex_memread & ex_valid & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - stall_id = load_use & ~flush.
  - Comparing rs2 is conservative for I-type instructions; this is accepted.
- EX forwarding (combinational, from registered rs fields) for rsN:
  - If mem_regwen & mem_rd_addr!=0 & mem_rd_addr==rsN: use mem_alu_result.
  - Else if wb_regwen & wb_rd_addr!=0 & wb_rd_addr==rsN: use wb_data.
  - Else: use the registered data.
  - MEM has priority over WB. x0 is never forwarded.
- Operand selection:
  - outmux1 = asel ? pc : fwd_rs1.
  - outmux2 = bsel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of bsel.
- Latency: ID values appear on the outputs one cycle after capture. The forwarding path is zero-latency within the EX cycle.
- Bubble and outmux: forwarding keys are zeroed in a bubble, so outmux cannot pick up a forwarded value. ALUSel=0000 (add) on the held operands is harmless because all enables are 0.
- Flush and stall together: flush wins, a bubble is loaded, and stall_id=0.

Test Plan:
1. Reset: assert rst with any inputs -> next cycle all outputs 0, stall_id=0.
2. Plain load of an add: rs1 data 5, rs2 data 7, asel=0, bsel=0, ALUSel=0000 -> next cycle outmux1=5, outmux2=7, ALUSel=0000, ex_valid=1.
3. Forward priority: EX holds rs1=x3, mem writes x3=0x11 and wb writes x3=0x22 in the same cycle -> outmux1=0x11. With mem_regwen=0 -> outmux1=0x22. With rs1=x0 and both writing x0 -> outmux1 = registered value.
4. Load-use: EX holds lw to x4, ID reads x4 -> stall_id=1 and the next EX is a bubble (ex_valid=0, regwen=0). The cycle after, the dependent instruction loads, and with wb forwarding wb_data appears on outmux1.
5. Flush with stall: flush=1 together with a load_use condition -> stall_id=0 and a bubble is loaded. hold=1 with flush=1 -> registers unchanged.
6. Capture bypass and immediate: wb writes x6=0xABCD in the capture cycle, ID reads rs2=x6 with stale 0 and bsel=1, imm=0xFFFFFFF0 -> outmux2=0xFFFFFFF0, ex_store_data=0xABCD.
